serial_frame_rx: RTL and testbench

- Serial front-end that sits directly upstream of parity_checker.
- Oversamples the asynchronous serial line rxin and frames each character as start, 8 data bits LSB first, parity bit, stop.
- For each good frame, presents the data byte plus the received parity bit and pulses load so parity_checker can evaluate it.
- Reports framing errors and line-break conditions itself; it does not check parity.

---
 rtl/serial_frame_rx_if.sv | 22 ++
 rtl/serial_frame_rx.sv | 170 +++++++++++++++++
 tb/tb_serial_frame_rx.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// Serial receiver bus: the raw line in, the framed byte and status strobes out.
// master drives the line and observes results; slave is the receiver itself.
interface serial_frame_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rxin;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rx_parity;
    logic                  load;
    logic                  framing_error;
    logic                  busy;

    modport master (
        output rxin,
        input  dout, rx_parity, load, framing_error, busy
    );

    modport slave (
        input  rxin,
        output dout, rx_parity, load, framing_error, busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Oversampling serial receiver: start, DATA_WIDTH bits LSB first, parity, stop.
// Presents each good byte with its received parity bit and flags bad stop bits.
module serial_frame_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    serial_frame_rx_if.slave   bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  w_line;
    logic [CNT_W-1:0]      r_cnt;
    logic [BIT_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_hold;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_rx_parity;
    logic                  r_load;
    logic                  r_fe;
    logic                  r_busy;
    logic                  w_half_tick;
    logic                  w_full_tick;
    logic                  w_load_next;
    logic                  w_fe_next;
    logic                  w_busy_next;

    assign w_line      = r_sync2;
    assign w_half_tick = (r_cnt == HALF_M1);
    assign w_full_tick = (r_cnt == FULL_M1);

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rxin;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_line) w_next_state = S_START;
                else         w_next_state = S_IDLE;
            end
            S_START: begin
                if (w_half_tick) w_next_state = w_line ? S_IDLE : S_DATA;
                else             w_next_state = S_START;
            end
            S_DATA: begin
                if (w_full_tick && (r_bit_idx == LAST_BIT)) w_next_state = S_PARITY;
                else                                        w_next_state = S_DATA;
            end
            S_PARITY: begin
                if (w_full_tick) w_next_state = S_STOP;
                else             w_next_state = S_PARITY;
            end
            S_STOP: begin
                if (w_full_tick) w_next_state = w_line ? S_IDLE : S_WAIT_IDLE;
                else             w_next_state = S_STOP;
            end
            S_WAIT_IDLE: begin
                if (w_line) w_next_state = S_IDLE;
                else        w_next_state = S_WAIT_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM output decode; busy stays up through the strobe cycle back in IDLE.
    always_comb begin
        w_load_next = (r_state == S_STOP) && w_full_tick && w_line;
        w_fe_next   = (r_state == S_STOP) && w_full_tick && !w_line;
        w_busy_next = (w_next_state != S_IDLE) || w_load_next || w_fe_next;
    end

    // Sample counter, bit index, shift register and held parity bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= {CNT_W{1'b0}};
            r_bit_idx  <= {BIT_W{1'b0}};
            r_shift    <= {DATA_WIDTH{1'b0}};
            r_par_hold <= 1'b0;
        end else begin
            case (r_state)
                S_START: begin
                    r_cnt     <= w_half_tick ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
                    r_bit_idx <= {BIT_W{1'b0}};
                end
                S_DATA: begin
                    r_cnt <= w_full_tick ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
                    if (w_full_tick) begin
                        r_shift   <= {w_line, r_shift[DATA_WIDTH-1:1]};
                        r_bit_idx <= r_bit_idx + BIT_W'(1);
                    end
                end
                S_PARITY: begin
                    r_cnt <= w_full_tick ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
                    if (w_full_tick) r_par_hold <= w_line;
                end
                S_STOP: begin
                    r_cnt <= w_full_tick ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
                end
                default: begin
                    r_cnt     <= {CNT_W{1'b0}};
                    r_bit_idx <= {BIT_W{1'b0}};
                end
            endcase
        end
    end

    // Registered outputs; dout/rx_parity only move together with load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout      <= {DATA_WIDTH{1'b0}};
            r_rx_parity <= 1'b0;
            r_load      <= 1'b0;
            r_fe        <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_load <= w_load_next;
            r_fe   <= w_fe_next;
            r_busy <= w_busy_next;
            if (w_load_next) begin
                r_dout      <= r_shift;
                r_rx_parity <= r_par_hold;
            end
        end
    end

    assign bus.dout          = r_dout;
    assign bus.rx_parity     = r_rx_parity;
    assign bus.load          = r_load;
    assign bus.framing_error = r_fe;
    assign bus.busy          = r_busy;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: frame table plus glitch, break and
// mid-frame reset sequences; strobes are matched against a scoreboard queue.
module tb_serial_frame_rx;

    localparam int CPB = 16;
    localparam int DW  = 8;

    typedef struct {
        logic       is_fe;
        logic [7:0] data;
        logic       par;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       gap;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    serial_frame_rx_if #(.DATA_WIDTH(DW)) sif ();

    serial_frame_rx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    vec_t       vecs[6];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         last_load_cyc = 0;
    int         stab_err = 0;
    int         n_fe = 0;
    logic [7:0] exp_dout = 8'h00;
    logic       exp_par  = 1'b0;

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive_bit(input logic b);
        sif.rxin = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    task automatic idle_cycles(input int n);
        sif.rxin = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(input string name);
        for (int i = 0; i < 400; i++) begin
            if (!sif.busy && sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check(name, !sif.busy && sb.size() == 0, 32'({sif.busy, 8'(sb.size())}), 32'h0);
    endtask

    initial begin
        int   start_cyc;
        int   fe0;
        logic saw;
        logic drop;

        sif.rxin = 1'b1;
        vecs[0] = '{data: 8'hA5, par: 1'b1, stop: 1'b1, gap: 1'b0};
        vecs[1] = '{data: 8'h3C, par: 1'b0, stop: 1'b1, gap: 1'b1};
        vecs[2] = '{data: 8'h09, par: 1'b0, stop: 1'b1, gap: 1'b1};
        vecs[3] = '{data: 8'h77, par: 1'b0, stop: 1'b0, gap: 1'b1};
        vecs[4] = '{data: 8'h55, par: 1'b0, stop: 1'b1, gap: 1'b1};
        vecs[5] = '{data: 8'hC3, par: even_par(8'hC3) ^ 1'b1, stop: 1'b1, gap: 1'b1};

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                exp_t e;
                @(negedge clk);
                if (reset) begin
                    if (sif.load || sif.framing_error) begin
                        check("strobe_overlap", !(sif.load && sif.framing_error),
                              32'({sif.load, sif.framing_error}), 32'h0);
                        check("unexpected_strobe", sb.size() != 0,
                              32'({sif.load, sif.framing_error}), 32'h0);
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            check("strobe_kind", sif.framing_error == e.is_fe,
                                  32'(sif.framing_error), 32'(e.is_fe));
                            if (!e.is_fe) begin
                                check("dout", sif.dout == e.data, 32'(sif.dout), 32'(e.data));
                                check("rx_parity", sif.rx_parity == e.par, 32'(sif.rx_parity), 32'(e.par));
                                exp_dout      = e.data;
                                exp_par       = e.par;
                                last_load_cyc = cyc;
                            end else begin
                                n_fe++;
                            end
                        end
                    end else if (sif.dout !== exp_dout || sif.rx_parity !== exp_par) begin
                        stab_err++;
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", sif.dout == 8'h00, 32'(sif.dout), 32'h0);
        check("rst_parity", sif.rx_parity == 1'b0, 32'(sif.rx_parity), 32'h0);
        check("rst_load", sif.load == 1'b0, 32'(sif.load), 32'h0);
        check("rst_fe", sif.framing_error == 1'b0, 32'(sif.framing_error), 32'h0);
        check("rst_busy", sif.busy == 1'b0, 32'(sif.busy), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle_cycles(6);
        check("idle_after_rst", sif.busy == 1'b0, 32'(sif.busy), 32'h0);

        // Frame table
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{is_fe: !vecs[i].stop, data: vecs[i].data, par: vecs[i].par});
            start_cyc = cyc;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            if (vecs[i].gap) idle_cycles(3 * CPB);
            if (i == 0)
                check("load_latency", (last_load_cyc - start_cyc) >= 166 && (last_load_cyc - start_cyc) <= 174,
                      32'(last_load_cyc - start_cyc), 32'd170);
            if (!vecs[i].stop)
                check("fe_dout_hold", sif.dout == exp_dout, 32'(sif.dout), 32'(exp_dout));
        end
        wait_quiet("table_drain");

        // Glitch shorter than half a bit
        sif.rxin = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        sif.rxin = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sif.busy) saw = 1'b1;
            @(posedge clk);
            #1;
        end
        check("glitch_busy_rise", saw, 32'(saw), 32'h1);
        check("glitch_busy_fall", sif.busy == 1'b0, 32'(sif.busy), 32'h0);
        check("glitch_dout_hold", sif.dout == exp_dout, 32'(sif.dout), 32'(exp_dout));

        // Break: line low for 40 bit times
        fe0 = n_fe;
        sb.push_back('{is_fe: 1'b1, data: 8'h00, par: 1'b0});
        sif.rxin = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        drop = 1'b0;
        for (int i = 0; i < 40 * CPB - 6; i++) begin
            if (!sif.busy) drop = 1'b1;
            @(posedge clk);
            #1;
        end
        check("break_busy", !drop, 32'(drop), 32'h0);
        idle_cycles(3 * CPB);
        wait_quiet("break_drain");
        check("break_one_fe", (n_fe - fe0) == 1, 32'(n_fe - fe0), 32'h1);
        sb.push_back('{is_fe: 1'b0, data: 8'h12, par: 1'b0});
        send_frame(8'h12, 1'b0, 1'b1);
        idle_cycles(3 * CPB);
        wait_quiet("post_break_frame");

        // Reset during data bit 4
        sif.rxin = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            sif.rxin = 1'(8'hF0 >> i);
            repeat (CPB) @(posedge clk);
        end
        sif.rxin = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midframe_busy", sif.busy == 1'b1, 32'(sif.busy), 32'h1);
        #1;
        reset    = 1'b0;
        exp_dout = 8'h00;
        exp_par  = 1'b0;
        #1;
        check("async_rst_dout", sif.dout == 8'h00, 32'(sif.dout), 32'h0);
        check("async_rst_busy", sif.busy == 1'b0, 32'(sif.busy), 32'h0);
        check("async_rst_strobes", !sif.load && !sif.framing_error,
              32'({sif.load, sif.framing_error}), 32'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle_cycles(4);
        sb.push_back('{is_fe: 1'b0, data: 8'hF0, par: 1'b0});
        send_frame(8'hF0, 1'b0, 1'b1);
        idle_cycles(3 * CPB);
        wait_quiet("post_reset_frame");

        check("dout_stability", stab_err == 0, 32'(stab_err), 32'h0);
        check("scoreboard_empty", sb.size() == 0, 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
